// File: rtl/dav_pkg.sv
// Shared types and constants for the display path (magnitude estimator to
// graphics controller).
package dav_pkg;

  localparam int N_BINS = 16;
  localparam int BIN_W  = 14;

  typedef logic [BIN_W-1:0] bin_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    PROCESS = 2'd2,
    COMMIT  = 2'd3
  } smoother_state_t;

  // Hold counters are 8 bits wide; out-of-range frame counts saturate at 255.
  function automatic logic [7:0] hold_init(input int frames);
    if (frames > 255) begin
      return 8'd255;
    end else if (frames < 0) begin
      return 8'd0;
    end
    return 8'(frames);
  endfunction

endpackage

// File: rtl/bar_decay_lane.sv
// Next-value logic for one bar: instant attack, optional peak hold, then
// geometric decay floored at the current input. Hold is gated by BAR_SMOOTHER_PEAK_HOLD_EN.
module bar_decay_lane
  import dav_pkg::*;
#(
  parameter int W           = BIN_W,
  parameter int DECAY_SHIFT = 3,
  parameter int HOLD_FRAMES = 30
) (
  input  logic [W-1:0] s_i,
  input  logic [W-1:0] work_i,
  input  logic [7:0]   hold_i,
  output logic [W-1:0] work_o,
  output logic [7:0]   hold_o
);

  localparam logic [7:0] HOLD_INIT = hold_init(HOLD_FRAMES);

  logic [W-1:0] step;
  logic [W-1:0] decayed;
  logic         hold_active;

`ifdef BAR_SMOOTHER_PEAK_HOLD_EN
  assign hold_active = (hold_i != 8'd0);
`else
  logic unused_hold;
  assign unused_hold = ^hold_i;
  assign hold_active = 1'b0;
`endif

  always_comb begin
    step = work_i >> DECAY_SHIFT;
    // Small bars still fall by at least one so they reach exactly zero.
    if ((step == '0) && (work_i != '0)) begin
      step = {{(W-1){1'b0}}, 1'b1};
    end
    decayed = work_i - step;

    work_o = work_i;
    hold_o = hold_i;
    if (s_i >= work_i) begin
      work_o = s_i;
      hold_o = HOLD_INIT;
    end else if (hold_active) begin
      hold_o = hold_i - 8'd1;
    end else begin
      work_o = (decayed > s_i) ? decayed : s_i;
    end
  end

endmodule

// File: rtl/bar_smoother.sv
// Frame-synchronous peak-hold/decay filter: snapshot all bins, update one bin
// per cycle through a shared lane, then commit every bar at once.
// Peak hold storage exists only with BAR_SMOOTHER_PEAK_HOLD_EN defined.
module bar_smoother
  import dav_pkg::*;
#(
  parameter int N           = N_BINS,
  parameter int W           = BIN_W,
  parameter int DECAY_SHIFT = 3,
  parameter int HOLD_FRAMES = 30
) (
  input  logic            clk_50MHz,
  input  logic            rst,
  input  logic            frame_start,
  input  logic [W-1:0]    mag_in   [N],
  output logic [W-1:0]    bars_out [N],
  output logic            busy,
  output logic            done,
  output smoother_state_t state_dbg
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  smoother_state_t  state_q;
  logic [IDX_W-1:0] idx_q;
  logic             busy_q;
  logic             done_q;
  logic [W-1:0]     snap_q [N];
  logic [W-1:0]     work_q [N];
  logic [W-1:0]     bars_q [N];

  logic [W-1:0]     work_d;
  logic [7:0]       hold_d;
  logic [7:0]       hold_cur;

`ifdef BAR_SMOOTHER_PEAK_HOLD_EN
  logic [7:0]       hold_q [N];
  assign hold_cur = hold_q[idx_q];
`else
  logic [7:0]       unused_hold_d;
  assign hold_cur      = 8'd0;
  assign unused_hold_d = hold_d;
`endif

  bar_decay_lane #(
    .W           (W),
    .DECAY_SHIFT (DECAY_SHIFT),
    .HOLD_FRAMES (HOLD_FRAMES)
  ) u_lane (
    .s_i    (snap_q[idx_q]),
    .work_i (work_q[idx_q]),
    .hold_i (hold_cur),
    .work_o (work_d),
    .hold_o (hold_d)
  );

  // frame_start outside IDLE is dropped, never queued.
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < N; i++) begin
        snap_q[i] <= '0;
        work_q[i] <= '0;
        bars_q[i] <= '0;
`ifdef BAR_SMOOTHER_PEAK_HOLD_EN
        hold_q[i] <= 8'd0;
`endif
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (frame_start) begin
            state_q <= CAPTURE;
          end
        end
        CAPTURE: begin
          for (int i = 0; i < N; i++) begin
            snap_q[i] <= mag_in[i];
          end
          idx_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= PROCESS;
        end
        PROCESS: begin
          work_q[idx_q] <= work_d;
`ifdef BAR_SMOOTHER_PEAK_HOLD_EN
          hold_q[idx_q] <= hold_d;
`endif
          if (idx_q == LAST_IDX) begin
            state_q <= COMMIT;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        COMMIT: begin
          for (int i = 0; i < N; i++) begin
            bars_q[i] <= work_q[i];
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bars_out  = bars_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_bar_smoother.sv
// Bench for bar_smoother: frame-level behavioural model checked every cycle,
// plus literal bar sequences for the hold/decay corner cases.
module tb_bar_smoother;
  import dav_pkg::*;

  localparam int N  = N_BINS;
  localparam int W  = BIN_W;
  localparam int DS = 3;
  localparam int HF = 2;
`ifdef BAR_SMOOTHER_PEAK_HOLD_EN
  localparam bit HOLD_ON = 1'b1;
`else
  localparam bit HOLD_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            frame_start;
  logic [W-1:0]    mag_in   [N];
  logic [W-1:0]    bars_out [N];
  logic            busy;
  logic            done;
  smoother_state_t state_dbg;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- clock ----------------
  always #10 clk = ~clk;

  bar_smoother #(
    .N (N), .W (W), .DECAY_SHIFT (DS), .HOLD_FRAMES (HF)
  ) dut (
    .clk_50MHz   (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .mag_in      (mag_in),
    .bars_out    (bars_out),
    .busy        (busy),
    .done        (done),
    .state_dbg   (state_dbg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Frame-level view: a frame is accepted when idle, inputs are captured one
  // cycle later, and N+1 cycles after that the whole frame's bars appear.
  int m_phase;
  int m_snap [N];
  int m_work [N];
  int m_hold [N];
  int m_bars [N];
  bit m_done, m_busy, m_live;

  initial m_live = 1'b0;

  function automatic void model_frame();
    for (int b = 0; b < N; b++) begin
      int s, w, d;
      s = m_snap[b];
      w = m_work[b];
      if (s >= w) begin
        w = s;
        m_hold[b] = HF;
      end else if (HOLD_ON && m_hold[b] > 0) begin
        m_hold[b] = m_hold[b] - 1;
      end else begin
        d = w / (1 << DS);
        if (d == 0 && w > 0) d = 1;
        w = w - d;
        if (w < s) w = s;
      end
      m_work[b] = w;
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0;
      m_done  = 1'b0;
      m_busy  = 1'b0;
      m_live  = 1'b1;
      for (int b = 0; b < N; b++) begin
        m_snap[b] = 0; m_work[b] = 0; m_hold[b] = 0; m_bars[b] = 0;
      end
    end else if (m_live) begin
      m_done = 1'b0;
      if (m_phase == 0) begin
        if (frame_start) m_phase = 1;
      end else if (m_phase == 1) begin
        for (int b = 0; b < N; b++) m_snap[b] = mag_in[b];
        m_busy  = 1'b1;
        m_phase = 2;
      end else if (m_phase < N + 2) begin
        m_phase++;
      end else begin
        model_frame();
        for (int b = 0; b < N; b++) m_bars[b] = m_work[b];
        m_done  = 1'b1;
        m_busy  = 1'b0;
        m_phase = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_live) begin
      int k;
      k = 0;
      for (int b = N - 1; b >= 0; b--) begin
        if (bars_out[b] !== m_bars[b][W-1:0]) k = b;
      end
      check("model_bars", 32'(bars_out[k]), 32'(m_bars[k]));
      check("model_done", 32'(done), 32'(m_done));
      check("model_busy", 32'(busy), 32'(m_busy));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fill_random(input int mode);
    for (int b = 0; b < N; b++) begin
      case (mode)
        0:       mag_in[b] = W'($urandom_range(0, (1 << W) - 1));
        1:       mag_in[b] = W'($urandom_range(0, 40));
        default: begin
          case ($urandom_range(0, 3))
            0:       mag_in[b] = '0;
            1:       mag_in[b] = '1;
            default: mag_in[b] = W'($urandom_range(0, (1 << W) - 1));
          endcase
        end
      endcase
    end
  endtask

  // Pulses frame_start and follows the frame. inject_at / reset_at (0 = off)
  // count cycles after the pulse was driven.
  task automatic run_frame(input bit back2back, input int inject_at, input int reset_at);
    int lat, bcnt;
    bit got;
    if (!back2back) @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    lat = 1; bcnt = 0; got = 1'b0;
    while (!got && lat < 60) begin
      if (done) begin
        got = 1'b1;
      end else begin
        if (busy) bcnt++;
        if (lat == 2) fill_random(0);
        frame_start = (lat == inject_at);
        rst         = (reset_at != 0) && (lat == reset_at);
        @(negedge clk);
        lat++;
      end
    end
    frame_start = 1'b0;
    rst         = 1'b0;
    if (reset_at != 0) begin
      check("abort_no_done", 32'(got), 32'd0);
    end else begin
      check("done_latency", 32'(lat), 32'(N + 3));
      check("busy_cycles", 32'(bcnt), 32'(N + 1));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- literal sequences ----------------
  int in3 [9] = '{800, 0, 0, 0, 0, 0, 0, 0, 0};
  int in0 [9] = '{5, 0, 0, 0, 0, 0, 0, 0, 0};
`ifdef BAR_SMOOTHER_PEAK_HOLD_EN
  int e3  [9] = '{800, 800, 800, 700, 613, 537, 470, 412, 361};
  int e0  [9] = '{5, 5, 5, 4, 3, 2, 1, 0, 0};
  int in7 [9] = '{800, 0, 0, 0, 650, 900, 0, 0, 0};
  int e7  [9] = '{800, 800, 800, 700, 650, 900, 900, 900, 788};
`else
  int e3  [9] = '{800, 700, 613, 537, 470, 412, 361, 316, 277};
  int e0  [9] = '{5, 4, 3, 2, 1, 0, 0, 0, 0};
  int in7 [9] = '{800, 0, 650, 900, 0, 0, 0, 0, 0};
  int e7  [9] = '{800, 700, 650, 900, 788, 690, 604, 529, 463};
`endif

  // ---------------- stimulus ----------------
  initial begin
    int ndone;
    rst = 1'b1;
    frame_start = 1'b0;
    for (int b = 0; b < N; b++) mag_in[b] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_state", 32'(state_dbg), 32'(IDLE));
    for (int b = 0; b < N; b++) check("reset_bar", 32'(bars_out[b]), 32'd0);

    // All-zero frame: bars stay zero.
    for (int b = 0; b < N; b++) mag_in[b] = '0;
    run_frame(1'b0, 0, 0);
    for (int b = 0; b < N; b++) check("zero_frame_bar", 32'(bars_out[b]), 32'd0);

    // Second frame_start while busy is dropped: exactly one done follows.
    fill_random(0);
    run_frame(1'b0, 5, 0);
    ndone = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("ignored_pulse_dones", 32'(ndone), 32'd0);

    // Reset mid-PROCESS discards the frame.
    do_reset();
    fill_random(0);
    run_frame(1'b0, 0, 8);
    check("abort_busy", 32'(busy), 32'd0);
    for (int b = 0; b < N; b++) check("abort_bar", 32'(bars_out[b]), 32'd0);

    // Hand-computed hold/decay sequences on bins 3, 0 and 7.
    do_reset();
    for (int f = 0; f < 9; f++) begin
      exp_q.push_back(W'(e3[f]));
      exp_q.push_back(W'(e0[f]));
      exp_q.push_back(W'(e7[f]));
    end
    for (int f = 0; f < 9; f++) begin
      logic [W-1:0] e;
      fill_random(1);
      mag_in[3] = W'(in3[f]);
      mag_in[0] = W'(in0[f]);
      mag_in[7] = W'(in7[f]);
      run_frame(f[0], 0, 0);
      e = exp_q.pop_front(); check("seq_bin3", 32'(bars_out[3]), 32'(e));
      e = exp_q.pop_front(); check("seq_bin0", 32'(bars_out[0]), 32'(e));
      e = exp_q.pop_front(); check("seq_bin7", 32'(bars_out[7]), 32'(e));
    end

    // 4095 on every bin commits in one cycle.
    do_reset();
    for (int b = 0; b < N; b++) mag_in[b] = W'(4095);
    run_frame(1'b0, 0, 0);
    for (int b = 0; b < N; b++) check("all_4095_bar", 32'(bars_out[b]), 32'd4095);

    // Random frames, mixed magnitude profiles and gaps (including back-to-back).
    for (int f = 0; f < 24; f++) begin
      fill_random($urandom_range(0, 2));
      run_frame($urandom_range(0, 1) == 1, 0, 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bar_smoother.md
# bar_smoother

Frame-synchronous peak-hold and decay filter between the magnitude estimator and the graphics controller. Once per video frame it snapshots the N bin magnitudes and updates each displayed bar. Rising input is followed instantly; falling input is held, then decays geometrically. Results are committed to the bar outputs atomically so the renderer never sees a partially updated frame.

## Interface
- N, default 16: number of frequency bins
- W, default 14: bin magnitude width, in bits
- DECAY_SHIFT, default 3: per-frame decay is bar >> DECAY_SHIFT
- HOLD_FRAMES, default 30: frames a new peak is held before decay starts; range 0..255

Ports:
- clk_50MHz, in, 1: system clock
- rst, in, 1: synchronous, active-high reset
- frame_start, in, 1: one-cycle pulse, already synchronised to clk_50MHz (vsync rising edge)
- mag_in, in, N×W: unpacked array of current bin magnitudes
- bars_out, out, N×W: committed bar heights
- busy, out, 1: high from snapshot through commit
- done, out, 1: one-cycle pulse on the cycle bars_out updates

## Operation
- States: IDLE, CAPTURE, PROCESS, COMMIT.
- IDLE:
  - frame_start=1 → CAPTURE.
  - frame_start while not IDLE is ignored; no queueing.
- CAPTURE: copy all of mag_in into snap[] in one cycle, set idx=0 → PROCESS.
- PROCESS: one bin per cycle, working on work[idx], hold[idx] and s=snap[idx]:
  - if s ≥ work: work=s, hold=HOLD_FRAMES.
  - else if hold>0: hold−1, work unchanged.
  - else: d = work>>DECAY_SHIFT; if d==0 and work>0 then d=1; work = max(work−d, s).
  - idx==N−1 → COMMIT; otherwise idx+1.
- COMMIT: bars_out ← work[] (all bins at once), pulse done → IDLE.
- Arithmetic is unsigned W-bit. Subtraction never underflows because d ≤ work. Bars reach exactly 0 when input is 0.
- hold[] is 8 bits wide.
- Reset, including mid-PROCESS:
  - state=IDLE; work[], hold[], snap[], bars_out all 0; busy=0, done=0.
  - The partial frame is discarded.

## Timing
- frame_start sampled at edge T → CAPTURE at T+1, PROCESS at T+2..T+N+1, COMMIT at T+N+2.
- bars_out and done are valid at T+N+3; 19 cycles total at N=16.
- busy is high at T+1 through T+N+2.
- frame_start at T+N+3 or later is accepted; IDLE is reachable the same cycle done pulses.
- mag_in needs to be stable only at the CAPTURE edge.
- bars_out changes only in COMMIT and holds between frames.

## Configuration
- BAR_SMOOTHER_PEAK_HOLD_EN defined: hold counters are implemented as described.
- Undefined: no hold[] storage. The hold>0 branch never applies, so decay starts on the first frame after a peak. HOLD_FRAMES is ignored.

## Structure
- Shared package dav_pkg holds:
  - N_BINS=16, BIN_W=14 constants
  - bin_t typedef (logic [BIN_W−1:0])
  - smoother_state_t enum {IDLE, CAPTURE, PROCESS, COMMIT}
- One sub-module, bar_decay_lane: combinational next-value logic (s, work, hold → work', hold'). It is instanced once and shared across bins via idx.

## Test plan
Defaults unless noted; DECAY_SHIFT=3, HOLD_FRAMES=2 with the macro defined.
- Reset, then one frame with mag_in all 0 → done at T+19; all bars 0; busy high exactly 17 cycles.
- Bin 3: input 800, then 0 for 5 frames → bar values 800, 800, 800, 700, 613, 537.
- Bin 0: bar=5, input 0, hold expired → 4, 3, 2, 1, 0, 0 (minimum decrement 1; no underflow).
- Decay floor: bar=700 (hold expired), input 650 → 650, not 613; input 900 → 900 and hold reloads to 2.
- frame_start pulsed at T+5 while busy → ignored, single done. Reset asserted at T+8 → bars stay 0, no done, busy=0 next cycle.
- Macro undefined: 800 then 0 → 800, 700, 613; 4095 on all 16 bins commits in the same cycle.
